// File: rtl/csa_pkg.sv
// csa_pkg -- shared constants and types for the dual-rail checker.
//   DEFAULT_WIDTH : default data width of the checked sum
//   chk_state_e   : checker FSM state (ST_OK, ST_FAULT)
package csa_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        ST_OK    = 1'b0,
        ST_FAULT = 1'b1
    } chk_state_e;

endpackage

// File: rtl/dual_rail_cmp.sv
// dual_rail_cmp -- combinational syndrome for a dual-rail (true/complement) sum.
// Ports:
//   s, s_invert    : true and complement sum rails (WIDTH)
//   c_out1, c_out2 : true and complement carry rails
//   syndrome       : WIDTH+1 bits, 1 where the two rails agree (i.e. are broken);
//                    bit WIDTH is the carry, bits WIDTH-1:0 the sum
//   any_err        : OR of the syndrome
module dual_rail_cmp
    import csa_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] s_invert,
    input  logic             c_out1,
    input  logic             c_out2,
    output logic [WIDTH:0]   syndrome,
    output logic             any_err
);

    // XNOR: a healthy pair is always complementary, so equality is the fault.
    assign syndrome = {c_out1 ~^ c_out2, s ~^ s_invert};
    assign any_err  = |syndrome;

endmodule

// File: rtl/dual_rail_checker.sv
// dual_rail_checker -- two-stage checker for a duplicated-carry dual-rail adder.
// Stage 1 captures the rails, the syndrome is formed between stages, stage 2
// presents the true-rail result with its syndrome. A two-state FSM keeps a
// sticky fault flag until err_clear.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   in_valid           : qualifies s, s_invert, c_out1, c_out2
//   s, s_invert        : true / complement sum rails (WIDTH)
//   c_out1, c_out2     : true / complement carry rails
//   err_clear          : clears sticky fault (and counter)
//   out_valid          : qualifies sum, carry, err_now, err_bits
//   sum, carry         : checked true-rail result (held when out_valid=0)
//   err_now, err_bits  : mismatch flag and WIDTH+1 syndrome (0 when out_valid=0)
//   err_sticky         : high while the FSM is in FAULT
//   err_count          : saturating count of bad words (CNT_W)
// Optional feature: define DUAL_RAIL_ERR_COUNT_EN to build the err_count port
// and its counter.
module dual_rail_checker
    import csa_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] s_invert,
    input  logic             c_out1,
    input  logic             c_out2,
    input  logic             err_clear,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             err_now,
    output logic [WIDTH:0]   err_bits,
    output logic             err_sticky
`ifdef DUAL_RAIL_ERR_COUNT_EN
    ,
    output logic [CNT_W-1:0] err_count
`endif
);

    // vld_pipe[0]: stage 1 valid, vld_pipe[1]: stage 2 valid (out_valid)
    logic [1:0]       vld_pipe;
    logic [WIDTH-1:0] s1_s;
    logic [WIDTH-1:0] s1_si;
    logic             s1_c1;
    logic             s1_c2;
    logic [WIDTH:0]   syndrome;
    logic             any_err;
    logic             err_hit;
    chk_state_e       state;
    chk_state_e       state_nxt;

    // Stage 1: load only on valid input so idle cycles leave data untouched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe[0] <= 1'b0;
            s1_s        <= '0;
            s1_si       <= '0;
            s1_c1       <= 1'b0;
            s1_c2       <= 1'b0;
        end else begin
            vld_pipe[0] <= in_valid;
            if (in_valid) begin
                s1_s  <= s;
                s1_si <= s_invert;
                s1_c1 <= c_out1;
                s1_c2 <= c_out2;
            end
        end
    end

    dual_rail_cmp #(.WIDTH(WIDTH)) u_cmp (
        .s        (s1_s),
        .s_invert (s1_si),
        .c_out1   (s1_c1),
        .c_out2   (s1_c2),
        .syndrome (syndrome),
        .any_err  (any_err)
    );

    // Stage 2: result holds across bubbles, error outputs drop to 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe[1] <= 1'b0;
            sum         <= '0;
            carry       <= 1'b0;
            err_bits    <= '0;
            err_now     <= 1'b0;
        end else begin
            vld_pipe[1] <= vld_pipe[0];
            if (vld_pipe[0]) begin
                sum      <= s1_s;
                carry    <= s1_c1;
                err_bits <= syndrome;
                err_now  <= any_err;
            end else begin
                err_bits <= '0;
                err_now  <= 1'b0;
            end
        end
    end

    assign out_valid = vld_pipe[1];
    assign err_hit   = vld_pipe[1] & err_now;

    // Fault FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_OK;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_OK:    if (err_hit) state_nxt = ST_FAULT;
            // a fresh error in the clearing cycle keeps the fault
            ST_FAULT: if (err_clear && !err_hit) state_nxt = ST_OK;
            default:  state_nxt = ST_OK;
        endcase
    end

    assign err_sticky = (state == ST_FAULT);

`ifdef DUAL_RAIL_ERR_COUNT_EN
    // Clear takes priority but still counts a coincident error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (err_clear) begin
            err_count <= err_hit ? CNT_W'(1) : '0;
        end else if (err_hit && (err_count != {CNT_W{1'b1}})) begin
            err_count <= err_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dual_rail_checker.sv
// tb_dual_rail_checker -- scoreboard bench for dual_rail_checker (WIDTH=8,
// CNT_W=2). Expected words are queued with their due cycle when driven and
// compared on the falling edge; the sticky flag and counter follow a small
// reference model.
module tb_dual_rail_checker;

    localparam int W = 8;
    localparam int CW = 2;

    typedef struct {
        int         due;
        logic [W-1:0] sum;
        logic       carry;
        logic [W:0] bits;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [W-1:0]  s = '0;
    logic [W-1:0]  s_invert = '0;
    logic          c_out1 = 1'b0;
    logic          c_out2 = 1'b0;
    logic          err_clear = 1'b0;
    logic          out_valid;
    logic [W-1:0]  sum;
    logic          carry;
    logic          err_now;
    logic [W:0]    err_bits;
    logic          err_sticky;
`ifdef DUAL_RAIL_ERR_COUNT_EN
    logic [CW-1:0] err_count;
`endif

    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    exp_t q[$];
    logic m_fault = 1'b0;
    int   m_cnt = 0;

    dual_rail_checker #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .s          (s),
        .s_invert   (s_invert),
        .c_out1     (c_out1),
        .c_out2     (c_out2),
        .err_clear  (err_clear),
        .out_valid  (out_valid),
        .sum        (sum),
        .carry      (carry),
        .err_now    (err_now),
        .err_bits   (err_bits),
        .err_sticky (err_sticky)
`ifdef DUAL_RAIL_ERR_COUNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One cycle of stimulus; words are due two cycles after they are driven.
    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c1, input logic c2, input logic clr);
        exp_t e;
        in_valid  = v;
        s         = a;
        s_invert  = b;
        c_out1    = c1;
        c_out2    = c2;
        err_clear = clr;
        if (v && !rst) begin
            e.due   = cyc + 2;
            e.sum   = a;
            e.carry = c1;
            for (int i = 0; i < W; i++) e.bits[i] = (a[i] == b[i]);
            e.bits[W] = (c1 == c2);
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // Output monitor and sticky/counter model, on the falling edge
    always @(negedge clk) begin
        logic hit;
        hit = 1'b0;
        if (rst) begin
            chk("rst_valid", out_valid, 0);
            chk("rst_errnow", err_now, 0);
            m_fault = 1'b0;
            m_cnt   = 0;
        end else begin
            if (q.size() != 0 && q[0].due < cyc) begin
                chk("lost_word", 0, 1);
                void'(q.pop_front());
            end
            if (q.size() != 0 && q[0].due == cyc) begin
                exp_t e;
                e = q.pop_front();
                chk("out_valid", out_valid, 1);
                chk("sum", sum, e.sum);
                chk("carry", carry, e.carry);
                chk("err_bits", err_bits, e.bits);
                chk("err_now", err_now, |e.bits);
                hit = |e.bits;
            end else begin
                chk("idle_valid", out_valid, 0);
                chk("idle_bits", err_bits, 0);
                chk("idle_errnow", err_now, 0);
            end
            chk("sticky", err_sticky, m_fault);
`ifdef DUAL_RAIL_ERR_COUNT_EN
            chk("count", err_count, m_cnt);
`endif
            // state after the coming rising edge
            if (m_fault) m_fault = hit || !err_clear;
            else         m_fault = hit;
            if (err_clear)               m_cnt = hit ? 1 : 0;
            else if (hit && m_cnt < 3)   m_cnt = m_cnt + 1;
        end
    end

    initial begin
        logic [W-1:0] r;
        // reset state
        #2;
        chk("rst_sum", sum, 0);
        chk("rst_carry", carry, 0);
        chk("rst_bits", err_bits, 0);
        chk("rst_sticky", err_sticky, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // clean word
        drive(1'b1, 8'h5A, 8'hA5, 1'b1, 1'b0, 1'b0);
        idle(3);
        // single sum-bit fault
        drive(1'b1, 8'h5A, 8'hA4, 1'b1, 1'b0, 1'b0);
        idle(3);
        chk("sticky_set", err_sticky, 1);
        // clear alone
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        idle(1);
        chk("sticky_clr", err_sticky, 0);
        // carry-rail fault, then clear
        drive(1'b1, 8'h5A, 8'hA5, 1'b1, 1'b1, 1'b0);
        idle(3);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        idle(1);
        // clear coincident with erroneous output: error wins
        drive(1'b1, 8'h33, 8'h33, 1'b0, 1'b1, 1'b0);
        idle(1);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        idle(1);
        chk("err_wins", err_sticky, 1);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        idle(1);
        // five bad words back to back: counter saturates
        for (int i = 0; i < 5; i++) drive(1'b1, 8'(i), 8'(i), 1'b1, 1'b0, 1'b0);
        idle(3);
`ifdef DUAL_RAIL_ERR_COUNT_EN
        chk("count_sat", err_count, 3);
`endif
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        idle(1);
        // random mix with occasional bubbles and clears
        for (int i = 0; i < 40; i++) begin
            r = 8'($urandom);
            drive(1'($urandom_range(0, 3) != 0), r,
                  ($urandom_range(0, 3) == 0) ? ~r ^ 8'($urandom) : ~r,
                  1'(i), ($urandom_range(0, 4) == 0) ? 1'(i) : ~1'(i),
                  1'($urandom_range(0, 5) == 0));
        end
        idle(3);

        // reset with two words in flight
        drive(1'b1, 8'hC3, 8'h3C, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 8'h0F, 8'h0F, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        q.delete();
        #1;
        chk("rstm_valid", out_valid, 0);
        chk("rstm_sum", sum, 0);
        chk("rstm_carry", carry, 0);
        chk("rstm_bits", err_bits, 0);
        chk("rstm_sticky", err_sticky, 0);
`ifdef DUAL_RAIL_ERR_COUNT_EN
        chk("rstm_count", err_count, 0);
`endif
        drive(1'b1, 8'h11, 8'hEE, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 8'h22, 8'hDD, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        idle(2);
        drive(1'b1, 8'h96, 8'h69, 1'b0, 1'b1, 1'b0);
        idle(4);
        chk("q_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
